// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for MEM-stage load/store requests. One request is
//   accepted at a time. It is held for WAIT_CYCLES wait states and then
//   performs a big-endian byte-lane access on an internal 2**AW word array.
//   Completion is signalled with a single-cycle ack.
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high (array contents kept)
//   ce_i     in   request valid; sampled only in IDLE
//   we_i     in   1 = store, 0 = load
//   addr_i   in   byte address; [1:0] ignored, [AW+1:2] word index
//   sel_i    in   byte-lane enables, sel_i[3] -> data[31:24] (byte offset 0)
//   data_i   in   store data
//   data_o   out  load data, updated on access, held until the next ack
//   ack_o    out  one-cycle completion pulse
//   err_o    out  out-of-range address, valid with ack_o
//   busy_o   out  request in flight
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        sel_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [2**AW];

  logic [AW-1:0]     word_idx;
  logic              in_range;
  logic [DATA_W-1:0] lane_mask;

  assign word_idx = addr_q[AW+1:2];
  // Any set bit above the word index means the address lies past the array.
  assign in_range = ((addr_q >> (AW + 2)) == '0);

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{sel_q[i]}};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ce_i) state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (cnt_q <= 4'd1) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and response registers
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (ce_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          sel_d   = sel_i;
          wdata_d = data_i;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: cnt_d = cnt_q - 4'd1;
      ACCESS: begin
        if (in_range) begin
          err_d = 1'b0;
          if (!we_q) rdata_d = mem[word_idx] & lane_mask;
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store commits on the edge leaving ACCESS; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS && we_q && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Outputs
  always_comb begin
    ack_o  = (state_q == DONE);
    err_o  = (state_q == DONE) && err_q;
    busy_o = (state_q != IDLE);
    data_o = rdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce0, ce1, we;
  logic [31:0] addr, din;
  logic [3:0]  sel;
  logic [31:0] dout0, dout1;
  logic        ack0, ack1, err0, err1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic [31:0] exp_data;
    logic        exp_err;
    logic        chk_data;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .AW(10), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(din), .data_o(dout0), .ack_o(ack0), .err_o(err0), .busy_o(busy0)
  );

  data_mem_responder #(.DATA_W(32), .AW(10), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(din), .data_o(dout1), .ack_o(ack1), .err_o(err1), .busy_o(busy1)
  );

  function automatic logic ack_of(input int u);
    return (u != 0) ? ack1 : ack0;
  endfunction
  function automatic logic err_of(input int u);
    return (u != 0) ? err1 : err0;
  endfunction
  function automatic logic busy_of(input int u);
    return (u != 0) ? busy1 : busy0;
  endfunction
  function automatic logic [31:0] dout_of(input int u);
    return (u != 0) ? dout1 : dout0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic c);
    exp_t x;
    x.exp_data = d;
    x.exp_err  = e;
    x.chk_data = c;
    sb.push_back(x);
  endtask

  // Called after the accept edge (edge 1); lat = edge count at which ack shows.
  task automatic wait_ack(input int u, input int lat);
    int   edges = 1;
    exp_t e;
    while (ack_of(u) == 1'b0 && edges < 40) begin
      tick();
      edges++;
    end
    chk("ack_seen", 32'(ack_of(u)), 32'd1);
    chk("latency", 32'(edges), 32'(lat));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: ack with no pending expectation (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      if (e.chk_data) chk("data_o", dout_of(u), e.exp_data);
      chk("err_o", 32'(err_of(u)), 32'(e.exp_err));
    end
    tick();
    chk("ack_pulse", 32'(ack_of(u)), 32'd0);
    chk("busy_after", 32'(busy_of(u)), 32'd0);
  endtask

  task automatic issue(input int u, input vec_t v, input int lat);
    we   = v.we;
    addr = v.addr;
    sel  = v.sel;
    din  = v.data;
    if (u != 0) ce1 = 1'b1; else ce0 = 1'b1;
    push(v.exp_data, v.exp_err, v.chk_data);
    tick();
    ce0 = 1'b0;
    ce1 = 1'b0;
    wait_ack(u, lat);
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic [31:0] ed,
                              input logic ee, input logic cd);
    vec_t v;
    v.we = w; v.addr = a; v.sel = s; v.data = d;
    v.exp_data = ed; v.exp_err = ee; v.chk_data = cd;
    return v;
  endfunction

  initial begin
    logic saw_ack;
    vec_t v;

    vecs[0]  = mk(1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 32'h10,       4'h1, 32'h000000AA, 32'h0,        1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEAA, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 32'h10,       4'hC, 32'h0,        32'hDEAD0000, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 32'h00010000, 4'hF, 32'h0,        32'h0,        1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEAA, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 32'h20,       4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 32'h14,       4'hF, 32'h01020304, 32'h0,        1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 32'h14,       4'h0, 32'h00000055, 32'h0,        1'b0, 1'b0);
    vecs[10] = mk(1'b0, 32'h14,       4'hF, 32'h0,        32'h01020304, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 32'h14,       4'h0, 32'h0,        32'h0,        1'b0, 1'b1);
    vecs[12] = mk(1'b1, 32'h0,        4'hF, 32'h11111111, 32'h0,        1'b0, 1'b0);
    vecs[13] = mk(1'b1, 32'h1000,     4'hF, 32'h22222222, 32'h0,        1'b1, 1'b1);
    vecs[14] = mk(1'b0, 32'h0,        4'hF, 32'h0,        32'h11111111, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 32'hFFC,      4'hF, 32'h00000000, 32'h0,        1'b0, 1'b0);
    vecs[16] = mk(1'b1, 32'hFFF,      4'h6, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0);
    vecs[17] = mk(1'b0, 32'hFFE,      4'hF, 32'h0,        32'h00A5A500, 1'b0, 1'b1);

    rst = 1'b1; ce0 = 1'b0; ce1 = 1'b0; we = 1'b0;
    addr = '0; sel = '0; din = '0;
    tick();
    tick();
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_data", dout0, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) issue(0, vecs[i], 4);

    // Reset during WAIT aborts a store: no ack, no write.
    we = 1'b1; addr = 32'h20; sel = 4'hF; din = 32'h12345678; ce0 = 1'b1;
    tick();
    ce0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ack0) saw_ack = 1'b1;
      tick();
    end
    chk("abort_wait_noack", 32'(saw_ack), 32'd0);
    chk("abort_wait_busy", 32'(busy0), 32'd0);

    // Reset on the edge leaving ACCESS must also suppress the write.
    we = 1'b1; addr = 32'h20; sel = 4'hF; din = 32'h99999999; ce0 = 1'b1;
    tick();
    ce0 = 1'b0;
    tick();
    tick();
    chk("in_access_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_access_ack", 32'(ack0), 32'd0);
    chk("abort_access_busy", 32'(busy0), 32'd0);
    tick();
    issue(0, mk(1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1), 4);

    // Reset and ce_i together: request dropped.
    we = 1'b0; addr = 32'h10; sel = 4'hF; ce0 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; ce0 = 1'b0;
    chk("rst_ce_busy", 32'(busy0), 32'd0);
    tick();
    chk("rst_ce_busy2", 32'(busy0), 32'd0);

    // ce_i held high; inputs change mid-flight; back-to-back acceptance.
    we = 1'b1; addr = 32'h30; sel = 4'hF; din = 32'h0BADF00D; ce0 = 1'b1;
    push(32'h0, 1'b0, 1'b0);
    tick();
    we = 1'b0; addr = 32'h30; sel = 4'hF; din = 32'hFFFFFFFF;
    wait_ack(0, 4);
    push(32'h0BADF00D, 1'b0, 1'b1);
    tick();
    ce0 = 1'b0;
    chk("b2b_accepted", 32'(busy0), 32'd1);
    wait_ack(0, 4);

    // Zero wait states: latency 2.
    v = mk(1'b1, 32'h40, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0);
    issue(1, v, 2);
    v = mk(1'b0, 32'h40, 4'h3, 32'h0, 32'h00005A5A, 1'b0, 1'b1);
    issue(1, v, 2);
    v = mk(1'b0, 32'h2000, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1, v, 2);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
